// File: rtl/dbg_pkg.sv
//------------------------------------------------------------------------------
// dbg_pkg : shared debug defines (halt-controller state codes, parameter defaults)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package dbg_pkg;

  localparam logic [2:0] DBG_ST_RUN    = 3'd0;
  localparam logic [2:0] DBG_ST_DRAIN  = 3'd1;
  localparam logic [2:0] DBG_ST_HALTED = 3'd2;
  localparam logic [2:0] DBG_ST_ACCESS = 3'd3;
  localparam logic [2:0] DBG_ST_RESET  = 3'd4;

  typedef enum logic [2:0] {
    ST_RUN    = DBG_ST_RUN,
    ST_DRAIN  = DBG_ST_DRAIN,
    ST_HALTED = DBG_ST_HALTED,
    ST_ACCESS = DBG_ST_ACCESS,
    ST_RESET  = DBG_ST_RESET
  } dbg_state_e;

  localparam int unsigned DBG_RST_PULSE_CYCLES_DEF = 8;
  localparam int unsigned DBG_DRAIN_TIMEOUT_DEF    = 255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_halt_ctrl.sv
//------------------------------------------------------------------------------
// dbg_halt_ctrl : core halt / debug-access / reset-pulse controller (Moore FSM)
// Optional drain timeout enabled by defining DBG_HALT_CTRL_TIMEOUT_EN.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module dbg_halt_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES = DBG_RST_PULSE_CYCLES_DEF,
  parameter int unsigned DRAIN_TIMEOUT    = DBG_DRAIN_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_req_i,
  input  logic reset_req_i,
  input  logic op_req_i,
  input  logic core_idle_i,
  output logic core_stall_o,
  output logic core_rst_o,
  output logic dbg_grant_o,
  output logic halted_o,
  output logic timeout_o
);

  localparam logic [7:0] RST_LAST = 8'(RST_PULSE_CYCLES - 1);

  dbg_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rr_q;
  logic       rr_rise;

`ifdef DBG_HALT_CTRL_TIMEOUT_EN
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
  logic to_set;
  logic timeout_q;
`endif

  assign rr_rise = reset_req_i & ~rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= reset_req_i;
    end
  end

  // One counter serves both the reset pulse and the drain timeout; it is
  // cleared on every entry into the state that uses it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DBG_HALT_CTRL_TIMEOUT_EN
    to_set  = 1'b0;
`endif
    if (rr_rise) begin
      state_d = ST_RESET;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req_i || op_req_i) begin
            state_d = ST_DRAIN;
            cnt_d   = 8'd0;
          end
        end
        ST_DRAIN: begin
          if (core_idle_i) begin
            state_d = ST_HALTED;
          end
`ifdef DBG_HALT_CTRL_TIMEOUT_EN
          else if (cnt_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
            to_set  = 1'b1;
          end
          cnt_d = sat_inc8(cnt_q);
`endif
        end
        ST_HALTED: begin
          if (op_req_i) begin
            state_d = ST_ACCESS;
          end else if (!halt_req_i) begin
            state_d = ST_RUN;
          end
        end
        ST_ACCESS: begin
          if (!op_req_i) begin
            state_d = ST_HALTED;
          end
        end
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = halt_req_i ? ST_HALTED : ST_RUN;
          end else begin
            cnt_d = sat_inc8(cnt_q);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

`ifdef DBG_HALT_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (rr_rise) begin
      timeout_q <= 1'b0;
    end else if (to_set) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  // DRAIN_TIMEOUT only matters in the timeout build; kept for a uniform interface.
  if (DRAIN_TIMEOUT == 0) begin : g_drain_timeout_unused
  end

  assign timeout_o = 1'b0;
`endif

  assign core_stall_o = (state_q != ST_RUN);
  assign core_rst_o   = (state_q == ST_RESET);
  assign dbg_grant_o  = (state_q == ST_ACCESS);
  assign halted_o     = (state_q == ST_HALTED) || (state_q == ST_ACCESS);

endmodule

`default_nettype wire

// File: tb/tb_dbg_halt_ctrl.sv
//------------------------------------------------------------------------------
// tb_dbg_halt_ctrl : directed + randomized self-checking bench for dbg_halt_ctrl
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dbg_halt_ctrl;

  localparam int unsigned P_RST = 8;
  localparam int unsigned P_DT  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt_req = 1'b0;
  logic reset_req = 1'b0;
  logic op_req = 1'b0;
  logic core_idle = 1'b0;
  logic core_stall, core_rst, dbg_grant, halted, timeout;

  int total = 0;
  int bad   = 0;

  dbg_halt_ctrl #(
    .RST_PULSE_CYCLES(P_RST),
    .DRAIN_TIMEOUT   (P_DT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_req_i  (halt_req),
    .reset_req_i (reset_req),
    .op_req_i    (op_req),
    .core_idle_i (core_idle),
    .core_stall_o(core_stall),
    .core_rst_o  (core_rst),
    .dbg_grant_o (dbg_grant),
    .halted_o    (halted),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: mode names instead of codes, reset pulse as a countdown,
  // drain as an elapsed-cycle count.
  typedef enum int {M_RUN, M_DRAIN, M_HALTED, M_ACCESS, M_RESET} mode_t;
  mode_t m_mode = M_RUN;
  int    m_pulse_left = 0;
  int    m_drain_elapsed = 0;
  bit    m_prev_rr = 1'b0;
  bit    m_to = 1'b0;
  bit    m_rise;

`ifdef DBG_HALT_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_RUN; m_pulse_left = 0; m_drain_elapsed = 0; m_prev_rr = 0; m_to = 0;
    end else begin
      m_rise    = reset_req && !m_prev_rr;
      m_prev_rr = reset_req;
      if (m_rise) begin
        m_mode = M_RESET; m_pulse_left = P_RST; m_to = 0;
      end else begin
        case (m_mode)
          M_RUN:    if (halt_req || op_req) begin m_mode = M_DRAIN; m_drain_elapsed = 0; end
          M_DRAIN: begin
            m_drain_elapsed++;
            if (core_idle) m_mode = M_HALTED;
            else if (TO_EN && m_drain_elapsed >= P_DT) begin m_mode = M_HALTED; m_to = 1; end
          end
          M_HALTED: if (op_req) m_mode = M_ACCESS; else if (!halt_req) m_mode = M_RUN;
          M_ACCESS: if (!op_req) m_mode = M_HALTED;
          M_RESET: begin
            m_pulse_left--;
            if (m_pulse_left == 0) m_mode = halt_req ? M_HALTED : M_RUN;
          end
          default: m_mode = M_RUN;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_stall",  core_stall, m_mode != M_RUN);
      chk("model_rst",    core_rst,   m_mode == M_RESET);
      chk("model_grant",  dbg_grant,  m_mode == M_ACCESS);
      chk("model_halted", halted,     m_mode == M_HALTED || m_mode == M_ACCESS);
      chk("model_timeout", timeout,   m_to);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int g_cnt, h_cnt, r_cnt;

  initial begin
    // reset state, asserted mid-cycle
    #3;
    chk("reset_stall", core_stall, 1'b0);
    chk("reset_rst", core_rst, 1'b0);
    chk("reset_grant", dbg_grant, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    cyc(2);
    rst = 1'b0;

    // halt with an already idle core
    halt_req = 1; core_idle = 1;
    cyc(1);
    chk("halt_stall_c1", core_stall, 1'b1);
    chk("halt_halted_c1", halted, 1'b0);
    cyc(1);
    chk("halt_halted_c2", halted, 1'b1);

    // debug access window of 5 cycles
    g_cnt = 0; h_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc(1);
      if (dbg_grant) g_cnt++;
      if (halted) h_cnt++;
      op_req = (i < 5);
    end
    chk_int("grant_cycles", g_cnt, 5);
    chk_int("halted_during_access", h_cnt, 10);

    halt_req = 0;
    cyc(1);
    chk("resume_stall", core_stall, 1'b0);

    // reset request held high: single pulse of P_RST cycles
    reset_req = 1; r_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      if (core_rst) r_cnt++;
    end
    chk_int("rst_pulse_len", r_cnt, P_RST);
    chk("after_pulse_run", core_stall, 1'b0);
    reset_req = 0;
    cyc(1);

    // reset edge during access
    halt_req = 1; op_req = 1; core_idle = 1;
    cyc(3);
    chk("access_reached", dbg_grant, 1'b1);
    reset_req = 1;
    cyc(1);
    chk("access_rst_grant", dbg_grant, 1'b0);
    chk("access_rst_pulse", core_rst, 1'b1);
    // re-edge inside RESET restarts the count
    cyc(2); reset_req = 0; cyc(1); reset_req = 1;
    r_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (core_rst) r_cnt++;
    end
    chk_int("rst_restart_len", r_cnt, P_RST);
    chk("rst_end_halted", halted, 1'b1);
    chk("rst_end_grant_op", dbg_grant, 1'b1);
    reset_req = 0; op_req = 0; halt_req = 0;
    cyc(3);

    // drain with a busy core
    halt_req = 1; core_idle = 0;
    cyc(12);
    chk("drain_halted", halted, TO_EN);
    chk("drain_timeout", timeout, TO_EN);
    chk("drain_stall", core_stall, 1'b1);
    core_idle = 1; halt_req = 0;
    cyc(3);
    chk("timeout_sticky", timeout, TO_EN);

    // async reset mid pulse
    reset_req = 1;
    cyc(3);
    chk("pre_abort_rst", core_rst, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst", core_rst, 1'b0);
    chk("abort_stall", core_stall, 1'b0);
    chk("abort_timeout", timeout, 1'b0);
    cyc(1);
    reset_req = 0; halt_req = 0; op_req = 0;
    rst = 1'b0;
    cyc(1);

    // randomized traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 9) == 0) op_req = ~op_req;
      if ($urandom_range(0, 29) == 0) reset_req = ~reset_req;
      core_idle = ($urandom_range(0, 5) == 0);
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbg_halt_ctrl.md
DBG_HALT_CTRL -- requirements
Module: dbg_halt_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 8: number of cycles core_rst_o is held high per reset request, legal range 1..255.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 255: maximum number of cycles spent in DRAIN before a forced halt, legal range 1..255.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports clk, rst.
REQ-004 clk  input  1  block clock, same clock as the debug module.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 halt_req_i  input  1  level halt request from debug module.
REQ-007 reset_req_i  input  1  level reset request from debug module; only its rising edge acts.
REQ-008 op_req_i  input  1  level: debug module wants the core register/memory ports.
REQ-009 core_idle_i  input  1  core pipeline drained, no outstanding fetch/LSU.
REQ-010 core_stall_o  output  1  stall core issue/fetch.
REQ-011 core_rst_o  output  1  reset pulse to core.
REQ-012 dbg_grant_o  output  1  debug module owns register/memory ports (mux select).
REQ-013 halted_o  output  1  core halted status.
REQ-014 timeout_o  output  1  sticky flag: drain timed out.

Function
REQ-015 SHALL implement states RUN, DRAIN, HALTED, ACCESS, RESET; all outputs decoded from registered state (Moore), so each input change takes effect in the cycle after the sampling edge.
REQ-016 RUN: stall=0, grant=0, halted=0; halt_req_i|op_req_i -> DRAIN.
REQ-017 DRAIN: stall=1; core_idle_i -> HALTED; drain counter cleared on entry, incremented each cycle.
REQ-018 HALTED: stall=1, halted=1; op_req_i -> ACCESS; !halt_req_i & !op_req_i -> RUN.
REQ-019 ACCESS: stall=1, halted=1, grant=1; !op_req_i -> HALTED; grant never asserted outside ACCESS.
REQ-020 RESET: stall=1, core_rst=1 for exactly RST_PULSE_CYCLES cycles; then halt_req_i -> HALTED, else RUN.
REQ-021 Rising edge of reset_req_i (registered previous value, 0 after reset) SHALL move any state to RESET, with priority over all other transitions; in ACCESS grant drops the next cycle.
REQ-022 Rising edge of reset_req_i while in RESET SHALL restart the pulse count.
REQ-023 reset_req_i held high SHALL NOT retrigger.
REQ-024 Counters SHALL be 8 bits, saturating, no wrap.

Reset
REQ-025 During and after rst: state RUN; core_stall_o, core_rst_o, dbg_grant_o, halted_o, timeout_o all 0; counters 0; reset_req edge register 0.
REQ-026 rst asserted mid-operation SHALL abort any pulse or access immediately (asynchronously).

Configuration
REQ-027 With DBG_HALT_CTRL_TIMEOUT_EN defined: in DRAIN, if the counter reaches DRAIN_TIMEOUT without core_idle_i, SHALL force HALTED and set timeout_o; timeout_o cleared only by rst or by entering RESET.
REQ-028 Without DBG_HALT_CTRL_TIMEOUT_EN: no drain counter logic; DRAIN waits indefinitely; timeout_o tied 0.

Structure
REQ-029 State encoding localparams and the default values of RST_PULSE_CYCLES/DRAIN_TIMEOUT SHALL live in the shared debug defines package (dbg_pkg), included by the debug module and this block.
REQ-030 SHALL be a single flat module; no sub-module.

Verification
REQ-031 halt_req_i=1, core_idle_i=1 from cycle 0 -> stall at cycle 1, halted_o at cycle 2; halt_req_i=0 -> RUN, stall=0 one cycle later.
REQ-032 In HALTED, op_req_i=1 for 5 cycles -> dbg_grant_o high for exactly 5 cycles, one-cycle lag; halted_o stays 1.
REQ-033 reset_req_i 0->1 held 20 cycles, RST_PULSE_CYCLES=8 -> core_rst_o high exactly 8 cycles, no retrigger, then RUN.
REQ-034 reset_req_i rising edge during ACCESS -> grant 0 and core_rst_o 1 next cycle.
REQ-035 Macro defined, DRAIN_TIMEOUT=10, core_idle_i=0 -> HALTED after 10 DRAIN cycles, timeout_o=1 and sticky; macro undefined -> stays in DRAIN, timeout_o=0.
REQ-036 rst pulsed mid-RESET pulse -> core_rst_o and all outputs 0 asynchronously, state RUN.
